julia_pixel_scheduler: RTL and testbench

Frame-level scheduler that sits directly upstream of the per-pixel Julia iteration engine in each Julia worker.
- On `frame_start` it walks every pixel of a COLS×ROWS frame in raster order.
- For each pixel it generates the fixed-point complex starting point z and presents it, with the frame constant c, to the pixel calculator.
- It sequences the calculator's `calc_start`/`calc_done` protocol, then hands each finished 8-bit pixel plus its coordinates downstream over a valid/ready interface.

---
 rtl/julia_pixel_scheduler.sv | 161 ++++++++++++++++
 tb/tb_julia_pixel_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_scheduler.sv
// Frame scheduler for the Julia worker: walks a COLS x ROWS frame in raster order,
// feeds each pixel's starting z and the frame constant c to the calculator, and
// hands finished pixels downstream over valid/ready.
module julia_pixel_scheduler #(
  parameter int WIDTH      = 20,
  parameter int FRACTIONAL = 10,
  parameter int COLS       = 640,
  parameter int ROWS       = 480
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] real_origin,
  input  logic [WIDTH-1:0] imag_origin,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] c_real_in,
  input  logic [WIDTH-1:0] c_imag_in,
  output logic             calc_start,
  output logic [WIDTH-1:0] z_real_out,
  output logic [WIDTH-1:0] z_imag_out,
  output logic [WIDTH-1:0] c_real_out,
  output logic [WIDTH-1:0] c_imag_out,
  output logic [7:0]       iteration_out,
  input  logic             calc_done,
  input  logic [7:0]       pixel_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_pixel,
  output logic [9:0]       out_x,
  output logic [9:0]       out_y,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  // state | meaning
  // IDLE  | waiting for frame_start, handshake outputs low
  // CALC  | calc_start high; first cycle is the calculator's load cycle
  // HOLD  | result presented on out_*; calculator cleared
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [9:0] LAST_X = 10'(COLS - 1);
  localparam logic [9:0] LAST_Y = 10'(ROWS - 1);

  if (FRACTIONAL < 0 || FRACTIONAL >= WIDTH) begin : g_bad_frac
    $error("FRACTIONAL must lie inside WIDTH");
  end
  if (COLS < 1 || COLS > 1024 || ROWS < 1 || ROWS > 1024) begin : g_bad_size
    $error("COLS and ROWS must be within 1..1024");
  end

  logic [1:0]       state;
  logic             load;
  logic [9:0]       x;
  logic [9:0]       y;
  logic [WIDTH-1:0] z_real;
  logic [WIDTH-1:0] z_imag;
  logic [WIDTH-1:0] c_real;
  logic [WIDTH-1:0] c_imag;
  logic [WIDTH-1:0] origin_real;
  logic [WIDTH-1:0] step_q;
  logic [7:0]       pixel_q;
  logic             last_q;
  logic             frame_done_q;

  logic [9:0] x_inc;
  logic [9:0] y_inc;
  logic       last_pix;
  logic       handshake;

  assign x_inc     = x + 10'd1;
  assign y_inc     = y + 10'd1;
  assign last_pix  = (x == LAST_X) && (y == LAST_Y);
  assign handshake = (state == ST_HOLD) && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      load         <= 1'b0;
      x            <= '0;
      y            <= '0;
      z_real       <= '0;
      z_imag       <= '0;
      c_real       <= '0;
      c_imag       <= '0;
      origin_real  <= '0;
      step_q       <= '0;
      pixel_q      <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state       <= ST_CALC;
            load        <= 1'b1;
            x           <= '0;
            y           <= '0;
            z_real      <= real_origin;
            z_imag      <= imag_origin;
            origin_real <= real_origin;
            step_q      <= step;
            c_real      <= c_real_in;
            c_imag      <= c_imag_in;
            last_q      <= (LAST_X == 10'd0) && (LAST_Y == 10'd0);
          end
        end
        ST_CALC: begin
          load <= 1'b0;
          // calc_done during the load cycle belongs to the previous pixel's clear
          if (!load && calc_done) begin
            pixel_q <= pixel_in;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            if (last_pix) begin
              state        <= ST_IDLE;
              frame_done_q <= 1'b1;
              last_q       <= 1'b0;
            end else begin
              state <= ST_CALC;
              load  <= 1'b1;
              if (x != LAST_X) begin
                x      <= x_inc;
                z_real <= z_real + step_q;
                last_q <= (x_inc == LAST_X) && (y == LAST_Y);
              end else begin
                x      <= '0;
                y      <= y_inc;
                z_real <= origin_real;
                z_imag <= z_imag - step_q;
                last_q <= (LAST_X == 10'd0) && (y_inc == LAST_Y);
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign calc_start    = (state == ST_CALC);
  assign out_valid     = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);
  assign z_real_out    = z_real;
  assign z_imag_out    = z_imag;
  assign c_real_out    = c_real;
  assign c_imag_out    = c_imag;
  assign iteration_out = 8'd0;
  assign out_pixel     = pixel_q;
  assign out_x         = x;
  assign out_y         = y;
  assign out_last      = last_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// Scoreboard bench for julia_pixel_scheduler: a 4x3 instance for the main frame
// scenarios and a 1x1 instance for the single-pixel and back-to-back cases.
module tb_julia_pixel_scheduler;

  typedef struct {
    logic [7:0]  pix;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        last;
    logic [19:0] zr;
    logic [19:0] zi;
    logic [19:0] cr;
    logic [19:0] ci;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic        frame_start = 1'b0;
  logic [19:0] real_origin = '0, imag_origin = '0, step = '0;
  logic [19:0] c_real_in = '0, c_imag_in = '0;
  logic        calc_done = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        out_ready = 1'b1;
  logic        calc_start, out_valid, out_last, busy, frame_done;
  logic [19:0] z_real_out, z_imag_out, c_real_out, c_imag_out;
  logic [7:0]  iteration_out, out_pixel;
  logic [9:0]  out_x, out_y;

  logic        frame_start_one = 1'b0;
  logic        calc_done_one = 1'b1;
  logic [7:0]  pixel_in_one = 8'h5A;
  logic        out_ready_one = 1'b1;
  logic        calc_start_one, out_valid_one, out_last_one, busy_one, frame_done_one;
  logic [19:0] z_real_one, z_imag_one, c_real_one, c_imag_one;
  logic [7:0]  iteration_one, out_pixel_one;
  logic [9:0]  out_x_one, out_y_one;

  julia_pixel_scheduler #(.WIDTH(20), .FRACTIONAL(10), .COLS(4), .ROWS(3)) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
    .real_origin(real_origin), .imag_origin(imag_origin), .step(step),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .calc_start(calc_start), .z_real_out(z_real_out), .z_imag_out(z_imag_out),
    .c_real_out(c_real_out), .c_imag_out(c_imag_out), .iteration_out(iteration_out),
    .calc_done(calc_done), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  julia_pixel_scheduler #(.WIDTH(20), .FRACTIONAL(10), .COLS(1), .ROWS(1)) dut_one (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start_one),
    .real_origin(real_origin), .imag_origin(imag_origin), .step(step),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in),
    .calc_start(calc_start_one), .z_real_out(z_real_one), .z_imag_out(z_imag_one),
    .c_real_out(c_real_one), .c_imag_out(c_imag_one), .iteration_out(iteration_one),
    .calc_done(calc_done_one), .pixel_in(pixel_in_one),
    .out_valid(out_valid_one), .out_ready(out_ready_one), .out_pixel(out_pixel_one),
    .out_x(out_x_one), .out_y(out_y_one), .out_last(out_last_one),
    .busy(busy_one), .frame_done(frame_done_one)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t q1[$];
  int   fd_cnt = 0;
  int   fd1_cnt = 0;
  bit   early = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Calculator model: done 3 cycles after calc_start rises, or tied high in early mode.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (calc_start) cnt++;
      else cnt = 0;
      calc_done = early || (cnt >= 3);
      pixel_in  = 8'(out_x + 10'd4 * out_y);
    end
  end

  // Monitor for the 4x3 instance.
  initial begin
    logic [19:0] cap_zr, cap_zi;
    logic [7:0]  h_pix;
    logic [9:0]  h_x, h_y;
    logic        h_last;
    bit          prev_hold;
    exp_t        e;
    cap_zr = '0; cap_zi = '0; prev_hold = 1'b0;
    h_pix = '0; h_x = '0; h_y = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_hold = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (calc_start) begin
          cap_zr = z_real_out;
          cap_zi = z_imag_out;
        end
        if (out_valid) begin
          chk("calc_start_low_in_hold", {31'd0, calc_start}, 32'd0);
          if (prev_hold) begin
            chk("hold_pixel_stable", {24'd0, out_pixel}, {24'd0, h_pix});
            chk("hold_x_stable", {22'd0, out_x}, {22'd0, h_x});
            chk("hold_y_stable", {22'd0, out_y}, {22'd0, h_y});
            chk("hold_last_stable", {31'd0, out_last}, {31'd0, h_last});
          end
          if (out_ready) begin
            prev_hold = 1'b0;
            if (q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_output x=%0d y=%0d pixel=%h expected=none", out_x, out_y, out_pixel);
            end else begin
              e = q.pop_front();
              chk("out_pixel", {24'd0, out_pixel}, {24'd0, e.pix});
              chk("out_x", {22'd0, out_x}, {22'd0, e.x});
              chk("out_y", {22'd0, out_y}, {22'd0, e.y});
              chk("out_last", {31'd0, out_last}, {31'd0, e.last});
              chk("z_real", {12'd0, cap_zr}, {12'd0, e.zr});
              chk("z_imag", {12'd0, cap_zi}, {12'd0, e.zi});
              chk("c_real", {12'd0, c_real_out}, {12'd0, e.cr});
              chk("c_imag", {12'd0, c_imag_out}, {12'd0, e.ci});
            end
          end else begin
            prev_hold = 1'b1;
            h_pix = out_pixel; h_x = out_x; h_y = out_y; h_last = out_last;
          end
        end else begin
          prev_hold = 1'b0;
        end
      end
    end
  end

  // Monitor for the 1x1 instance.
  initial begin
    logic [19:0] cap_zr;
    exp_t        e;
    cap_zr = '0;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (frame_done_one) fd1_cnt++;
        if (calc_start_one) cap_zr = z_real_one;
        if (out_valid_one && out_ready_one) begin
          if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL one_unexpected_output pixel=%h expected=none", out_pixel_one);
          end else begin
            e = q1.pop_front();
            chk("one_pixel", {24'd0, out_pixel_one}, {24'd0, e.pix});
            chk("one_x", {22'd0, out_x_one}, {22'd0, e.x});
            chk("one_y", {22'd0, out_y_one}, {22'd0, e.y});
            chk("one_last", {31'd0, out_last_one}, {31'd0, e.last});
            chk("one_z_real", {12'd0, cap_zr}, {12'd0, e.zr});
            chk("one_c_real", {12'd0, c_real_one}, {12'd0, e.cr});
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [19:0] orr, oi, st, cr, ci);
    exp_t e;
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        e.pix  = 8'(xx + 4 * yy);
        e.x    = 10'(xx);
        e.y    = 10'(yy);
        e.last = (xx == 3) && (yy == 2);
        e.zr   = orr + st * 20'(xx);
        e.zi   = oi - st * 20'(yy);
        e.cr   = cr;
        e.ci   = ci;
        q.push_back(e);
      end
    end
  endtask

  // Called just after a rising edge; returns the number of cycles busy was high.
  task automatic run_frame(input logic [19:0] orr, oi, st, cr, ci,
                           input bit bp, input bit rs, output int bc);
    bit done, bp_done;
    int bpn;
    real_origin = orr; imag_origin = oi; step = st;
    c_real_in = cr; c_imag_in = ci;
    push_frame(orr, oi, st, cr, ci);
    fd_cnt = 0;
    out_ready = 1'b1;
    frame_start = 1'b1;
    bc = 0; done = 1'b0; bp_done = !bp; bpn = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      frame_start = rs && (i == 10);
      if (rs && i == 10) begin
        real_origin = 20'h12345; imag_origin = 20'h54321; step = 20'h00777;
        c_real_in = 20'hABCDE; c_imag_in = 20'h0F0F0;
      end
      if (bpn > 0) begin
        bpn--;
        if (bpn == 0) out_ready = 1'b1;
      end else if (!bp_done && out_valid && out_x == 10'd1 && out_y == 10'd0) begin
        out_ready = 1'b0;
        bpn = 5;
        bp_done = 1'b1;
      end
      if (busy) bc++;
      if (frame_done) done = 1'b1;
    end
    chk("frame_done_seen", {31'd0, done}, 32'd1);
    chk("busy_low_with_frame_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    chk("frame_done_count", fd_cnt, 32'd1);
    chk("scoreboard_drained", q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    int   bc, nf;
    bit   pend;
    exp_t e1;

    #2;
    chk("rst_calc_start", {31'd0, calc_start}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_pixel", {24'd0, out_pixel}, 32'd0);
    chk("rst_out_x", {22'd0, out_x}, 32'd0);
    chk("rst_z_real", {12'd0, z_real_out}, 32'd0);
    chk("rst_c_imag", {12'd0, c_imag_out}, 32'd0);
    chk("iteration_out", {24'd0, iteration_out}, 32'd0);

    #10 n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame
    run_frame(20'hFF800, 20'h00400, 20'h00100, 20'h00123, 20'h00456, 1'b0, 1'b0, bc);
    // Back-pressure on (1,0)
    run_frame(20'hFF800, 20'h00400, 20'h00100, 20'h00123, 20'h00456, 1'b1, 1'b0, bc);
    // calc_done tied high: 3 cycles/pixel
    early = 1'b1;
    run_frame(20'hFF800, 20'h00400, 20'h00100, 20'h00321, 20'h00654, 1'b0, 1'b0, bc);
    chk("early_busy_cycles", bc, 32'd36);
    early = 1'b0;
    // frame_start mid-frame with different parameters
    run_frame(20'h00040, 20'hFFFC0, 20'h00010, 20'h00AAA, 20'h00BBB, 1'b0, 1'b1, bc);
    // Two's complement wrap
    run_frame(20'h7FFFF, 20'h00000, 20'h7FFFF, 20'h00001, 20'h00002, 1'b0, 1'b0, bc);

    // Reset mid-pixel
    real_origin = 20'h00100; imag_origin = 20'h00200; step = 20'h00010;
    c_real_in = 20'h00333; c_imag_in = 20'h00444;
    push_frame(20'h00100, 20'h00200, 20'h00010, 20'h00333, 20'h00444);
    fd_cnt = 0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_calc_start", {31'd0, calc_start}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_calc_start", {31'd0, calc_start}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_x", {22'd0, out_x}, 32'd0);
    chk("mid_rst_out_pixel", {24'd0, out_pixel}, 32'd0);
    chk("mid_rst_z_real", {12'd0, z_real_out}, 32'd0);
    chk("mid_rst_c_real", {12'd0, c_real_out}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("no_frame_done_after_abort", fd_cnt, 32'd0);
    chk("idle_after_abort", {31'd0, busy}, 32'd0);

    // 1x1 frames, second started in the frame_done cycle
    real_origin = 20'h00321; imag_origin = 20'h00654; step = 20'h00010;
    c_real_in = 20'h11111; c_imag_in = 20'h22222;
    e1.pix = 8'h5A; e1.x = '0; e1.y = '0; e1.last = 1'b1;
    e1.zr = 20'h00321; e1.zi = 20'h00654; e1.cr = 20'h11111; e1.ci = 20'h22222;
    q1.push_back(e1);
    fd1_cnt = 0;
    frame_start_one = 1'b1;
    nf = 0; pend = 1'b0;
    for (int i = 0; i < 100 && nf < 2; i++) begin
      @(posedge clk);
      #1;
      frame_start_one = 1'b0;
      if (pend) begin
        chk("b2b_busy", {31'd0, busy_one}, 32'd1);
        chk("b2b_calc_start", {31'd0, calc_start_one}, 32'd1);
        pend = 1'b0;
      end
      if (frame_done_one) begin
        nf++;
        if (nf == 1) begin
          q1.push_back(e1);
          frame_start_one = 1'b1;
          pend = 1'b1;
        end
      end
    end
    chk("one_frames_done", nf, 32'd2);
    @(posedge clk);
    #1;
    chk("one_frame_done_count", fd1_cnt, 32'd2);
    chk("one_scoreboard_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
